// File: rtl/switch_matrix_ctrl_mt8816.sv
// rtl/switch_matrix_ctrl_mt8816.sv - MT8816 crosspoint array controller with command FIFO
// Purpose: buffers host commands in a small FIFO and sequences the shared
//   AX/AY/DATA/STROBE bus plus per-chip CS and RESET_SW of N_SW MT8816 chips.
// Ports:
//   clk, rst                       clock, async active-high reset
//   cmd_valid/cmd_ready            command handshake (ready = FIFO not full)
//   cmd_op/cmd_sw/cmd_x/cmd_y/cmd_data  command fields
//   busy, done, err                status (done/err are 1-cycle pulses)
//   AX, AY, DATA, STROBE           shared chip bus
//   CS, RESET_SW                   per-chip select and reset
module switch_matrix_ctrl_mt8816 #(
  parameter int N_SW     = 2,
  parameter int DEPTH    = 4,
  parameter int T_RESET  = 6,
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 3,
  parameter int T_HOLD   = 2,
  parameter int T_GAP    = 1,
  localparam int SW_W    = (N_SW > 1) ? $clog2(N_SW) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [SW_W-1:0] cmd_sw,
  input  logic [3:0]      cmd_x,
  input  logic [2:0]      cmd_y,
  input  logic            cmd_data,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [3:0]      AX,
  output logic [2:0]      AY,
  output logic            DATA,
  output logic            STROBE,
  output logic [N_SW-1:0] CS,
  output logic [N_SW-1:0] RESET_SW
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 2 + SW_W + 4 + 3 + 1;
  localparam int T_MAX0 = (T_RESET > T_SETUP) ? T_RESET : T_SETUP;
  localparam int T_MAX1 = (T_MAX0 > T_STROBE) ? T_MAX0 : T_STROBE;
  localparam int T_MAX2 = (T_MAX1 > T_HOLD) ? T_MAX1 : T_HOLD;
  localparam int T_MAX  = (T_MAX2 > T_GAP) ? T_MAX2 : T_GAP;
  localparam int CW     = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] L_RESET  = CW'(T_RESET - 1);
  localparam logic [CW-1:0] L_SETUP  = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] L_STROBE = CW'(T_STROBE - 1);
  localparam logic [CW-1:0] L_HOLD   = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] L_GAP    = CW'(T_GAP - 1);

  if ((T_RESET < 1) || (T_SETUP < 1) || (T_STROBE < 1) || (T_HOLD < 1) || (T_GAP < 1)) begin : g_bad_timing
    $error("switch_matrix_ctrl_mt8816: every T_* parameter must be >= 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("switch_matrix_ctrl_mt8816: DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_STRB, S_HOLD, S_RSTP, S_GAP} state_t;

  // Logical X to physical AX: the MT8816 skips AX codes 6/7 for X6..X11.
  function automatic logic [3:0] ax_map(input logic [3:0] x);
    if (x >= 4'd6 && x <= 4'd11) return x + 4'd2;
    else if (x == 4'd12)         return 4'd6;
    else if (x == 4'd13)         return 4'd7;
    else                         return x;
  endfunction

  // Command FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          w_empty, w_full, w_push, w_pop;
  logic [EW-1:0] w_head;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;
  logic [SW_W-1:0] r_sw;
  logic [3:0]      r_x;
  logic [2:0]      r_y;
  logic            r_d;
  logic            r_flag;
  logic            w_sw_ok;
  logic [N_SW-1:0] w_sel;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push    = cmd_valid && !w_full;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign cmd_ready = !w_full;
  assign busy      = !w_empty || (r_state != S_IDLE);
  assign w_sw_ok   = (int'(r_sw) < N_SW);

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_SW; i++) w_sel[i] = (int'(r_sw) == i);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {cmd_op, cmd_sw, cmd_x, cmd_y, cmd_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_sw     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_d      <= 1'b0;
      r_flag   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      AX       <= '0;
      AY       <= '0;
      DATA     <= 1'b0;
      STROBE   <= 1'b0;
      CS       <= '0;
      RESET_SW <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_op, r_sw, r_x, r_y, r_d} <= w_head;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          AX     <= ax_map(r_x);
          AY     <= r_y;
          DATA   <= r_d;
          r_flag <= 1'b0;
          r_state <= S_GAP;
          r_cnt   <= L_GAP;
          case (r_op)
            2'd0: ;
            2'd1: begin
              if (w_sw_ok) begin
                CS      <= w_sel;
                r_state <= S_SETUP;
                r_cnt   <= L_SETUP;
              end else begin
                r_flag <= 1'b1;
              end
            end
            2'd2: begin
              if (w_sw_ok) begin
                RESET_SW <= w_sel;
                r_state  <= S_RSTP;
                r_cnt    <= L_RESET;
              end else begin
                r_flag <= 1'b1;
              end
            end
            default: begin
              RESET_SW <= '1;
              r_state  <= S_RSTP;
              r_cnt    <= L_RESET;
            end
          endcase
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            STROBE  <= 1'b1;
            r_state <= S_STRB;
            r_cnt   <= L_STROBE;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_STRB: begin
          if (r_cnt == '0) begin
            STROBE  <= 1'b0;
            r_state <= S_HOLD;
            r_cnt   <= L_HOLD;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            CS      <= '0;
            r_state <= S_GAP;
            r_cnt   <= L_GAP;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_RSTP: begin
          if (r_cnt == '0) begin
            RESET_SW <= '0;
            r_state  <= S_GAP;
            r_cnt    <= L_GAP;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            done    <= 1'b1;
            err     <= r_flag;
            r_state <= S_IDLE;
          end else r_cnt <= r_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_matrix_ctrl_mt8816.sv
// tb/tb_switch_matrix_ctrl_mt8816.sv - scoreboard bench for switch_matrix_ctrl_mt8816
module tb_switch_matrix_ctrl_mt8816;

  localparam int N_SW = 3;
  localparam int SW_W = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = '0;
  logic [SW_W-1:0] cmd_sw = '0;
  logic [3:0]      cmd_x = '0;
  logic [2:0]      cmd_y = '0;
  logic            cmd_data = 1'b0;
  logic            busy, done, err;
  logic [3:0]      AX;
  logic [2:0]      AY;
  logic            DATA, STROBE;
  logic [N_SW-1:0] CS, RESET_SW;

  switch_matrix_ctrl_mt8816 #(.N_SW(N_SW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sw(cmd_sw), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_data(cmd_data),
    .busy(busy), .done(done), .err(err), .AX(AX), .AY(AY), .DATA(DATA),
    .STROBE(STROBE), .CS(CS), .RESET_SW(RESET_SW)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id; int err; int cs; int rsw; int ax; int ay; int data;
    int cs_len; int strb_len; int strb_dly; int rst_len; int tail;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   viol = 0;

  int ax_tab[16] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 6, 7, 14, 15};

  function automatic void chk(input string nm, input int id, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (cmd %0d): got %0d, expected %0d", nm, id, act, exp);
    end
  endfunction

  function automatic exp_t e_base(input int id, input int ax, input int ay, input int d);
    exp_t e;
    e.id = id; e.err = 0; e.cs = 0; e.rsw = 0; e.ax = ax; e.ay = ay; e.data = d;
    e.cs_len = 0; e.strb_len = 0; e.strb_dly = 0; e.rst_len = 0; e.tail = 0;
    return e;
  endfunction

  function automatic exp_t e_write(input int id, input int sw, input int ax, input int ay, input int d);
    exp_t e = e_base(id, ax, ay, d);
    e.cs = 1 << sw; e.cs_len = 7; e.strb_len = 3; e.strb_dly = 2; e.tail = 2;
    return e;
  endfunction

  // Monitor: accumulates pin activity per command, compares on each done.
  int cyc = 0;
  int cs_or, rst_or, cs_len, strb_len, rst_len, first_cs, first_strb, last_act;

  function automatic void clr_stats();
    cs_or = 0; rst_or = 0; cs_len = 0; strb_len = 0; rst_len = 0;
    first_cs = -1; first_strb = -1; last_act = -1;
  endfunction

  initial clr_stats();

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      clr_stats();
    end else begin
      if (CS != '0) begin
        cs_or |= int'(CS); cs_len++; last_act = cyc;
        if (first_cs < 0) first_cs = cyc;
      end
      if (STROBE) begin
        strb_len++;
        if (first_strb < 0) first_strb = cyc;
      end
      if (RESET_SW != '0) begin
        rst_or |= int'(RESET_SW); rst_len++; last_act = cyc;
      end
      if (!$onehot0(CS) || (CS != '0 && RESET_SW != '0) || (STROBE && CS == '0) || (err && !done))
        viol++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", -1, 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("err", e.id, int'(err), e.err);
          chk("cs_pattern", e.id, cs_or, e.cs);
          chk("reset_pattern", e.id, rst_or, e.rsw);
          chk("ax", e.id, int'(AX), e.ax);
          chk("ay", e.id, int'(AY), e.ay);
          chk("data", e.id, int'(DATA), e.data);
          chk("cs_len", e.id, cs_len, e.cs_len);
          chk("strobe_len", e.id, strb_len, e.strb_len);
          chk("strobe_delay", e.id, (first_cs >= 0 && first_strb >= 0) ? first_strb - first_cs : 0, e.strb_dly);
          chk("reset_len", e.id, rst_len, e.rst_len);
          chk("done_tail", e.id, (last_act >= 0) ? cyc - last_act : 0, e.tail);
        end
        clr_stats();
      end
    end
  end

  task automatic push(input int op, input int sw, input int x, input int y, input int d,
                      input bit track, input exp_t e, output int waited);
    waited = 0;
    @(negedge clk);
    cmd_op = 2'(op); cmd_sw = SW_W'(sw); cmd_x = 4'(x); cmd_y = 3'(y); cmd_data = d[0];
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) chk("push_timeout", e.id, waited, 0);
    @(posedge clk);
    if (track) exp_q.push_back(e);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("drain_timeout", -1, exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int w;
    int busy_seen;
    int t;
    #1 rst = 1'b1;
    #1;
    chk("reset_cmd_ready", 0, int'(cmd_ready), 1);
    chk("reset_busy", 0, int'(busy), 0);
    chk("reset_pins", 0, int'({CS, RESET_SW, STROBE, AX, AY, DATA, done, err}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single write: sw=1, x=12 -> AX 6
    push(1, 1, 12, 5, 1, 1'b1, e_write(1, 1, 6, 5, 1), w);
    drain();

    // AX map sweep, streamed so the FIFO fills and stalls
    for (int x = 0; x < 16; x++)
      push(1, x % 3, x, x % 8, x % 2, 1'b1, e_write(100 + x, x % 3, ax_tab[x], x % 8, x % 2), w);
    drain();

    // RESET_ALL, then NOP, then bad index followed by a normal write
    begin
      exp_t e = e_base(2, 0, 0, 0);
      e.rsw = 7; e.rst_len = 6; e.tail = 2;
      push(3, 0, 0, 0, 0, 1'b1, e, w);
    end
    push(0, 0, 13, 4, 1, 1'b1, e_base(3, 7, 4, 1), w);
    begin
      exp_t e = e_base(4, 2, 1, 0);
      e.err = 1;
      push(2, 3, 2, 1, 0, 1'b1, e, w);
    end
    push(1, 2, 7, 3, 0, 1'b1, e_write(5, 2, 9, 3, 0), w);
    drain();

    // Back-to-back: first entry is popped right away, so the 5th push fills DEPTH=4
    for (int i = 0; i < 5; i++)
      push(1, i % 3, i + 1, i, 1, 1'b1, e_write(200 + i, i % 3, i + 1, i, 1), w);
    @(negedge clk);
    chk("full_cmd_ready", 205, int'(cmd_ready), 0);
    push(1, 0, 14, 7, 0, 1'b1, e_write(206, 0, 14, 7, 0), w);
    chk("full_stalled", 206, int'(w > 0), 1);
    drain();

    // Reset in the middle of the strobe: everything drops at once, no done
    push(1, 0, 3, 2, 1, 1'b0, e_base(300, 0, 0, 0), w);
    push(1, 1, 4, 2, 1, 1'b0, e_base(301, 0, 0, 0), w);
    t = 0;
    while (!STROBE && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("strobe_reached", 300, int'(STROBE), 1);
    rst = 1'b1;
    #1;
    chk("rst_cs", 300, int'(CS), 0);
    chk("rst_strobe", 300, int'(STROBE), 0);
    chk("rst_busy", 300, int'(busy), 0);
    chk("rst_cmd_ready", 300, int'(cmd_ready), 1);
    chk("rst_reset_sw", 300, int'(RESET_SW), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    chk("flushed_idle", 301, busy_seen, 0);

    push(1, 2, 15, 6, 1, 1'b1, e_write(7, 2, 15, 6, 1), w);
    drain();

    chk("pin_invariants", -1, viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
